// File: rtl/object_slot_scheduler_pkg.sv
// Shared types and slot map for the object slot scheduler.
// Slot 0 is the ship, then the bullet range, then the rock range.
package object_pkg;

    localparam int unsigned N_BULLETS = 4;
    localparam int unsigned N_ROCKS   = 10;
    localparam int unsigned N_SLOTS   = 1 + N_BULLETS + N_ROCKS;

    localparam int unsigned SHIP_IDX  = 0;
    localparam int unsigned BULLET_LO = 1;
    localparam int unsigned BULLET_HI = BULLET_LO + N_BULLETS - 1;
    localparam int unsigned ROCK_LO   = BULLET_HI + 1;
    localparam int unsigned ROCK_HI   = ROCK_LO + N_ROCKS - 1;

    localparam int unsigned LEVEL_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PLAY       = 3'd1,
        ST_RESPAWN    = 3'd2,
        ST_WAVE_CLEAR = 3'd3,
        ST_OVER       = 3'd4
    } state_t;

endpackage

// File: rtl/object_slot_scheduler_if.sv
// Control/event bus between the game logic and the slot scheduler.
// The master side drives game events; the slave side is the scheduler.
interface object_slot_scheduler_if;
    import object_pkg::*;

    logic                      start;
    logic                      fire_req;
    logic [N_SLOTS-1:0]        kill;
    logic [N_SLOTS-1:0]        slot_done;
    logic                      game_over;
    logic [N_SLOTS-1:0]        spawn;
    logic [N_SLOTS-1:0]        active;
    logic [LEVEL_W-1:0]        level;
    logic [2:0]                state_o;

    modport master (
        output start, fire_req, kill, slot_done, game_over,
        input  spawn, active, level, state_o
    );

    modport slave (
        input  start, fire_req, kill, slot_done, game_over,
        output spawn, active, level, state_o
    );

endinterface

// File: rtl/object_slot_scheduler_picker.sv
// Lowest-index picker: isolates the least significant set bit of a free mask.
module lowest_free_picker #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_free,
    output logic [W-1:0] o_grant,
    output logic         o_valid
);

    // x & -x keeps only the lowest set bit
    assign o_grant = i_free & (~i_free + W'(1));
    assign o_valid = |i_free;

endmodule

// File: rtl/object_slot_scheduler.sv
// Round sequencer for the ship, bullet and rock slots: spawns, frees and
// tracks live slots, and steps through respawn, wave clear and level-up.
module object_slot_scheduler
    import object_pkg::*;
#(
    parameter int unsigned FIRE_COOLDOWN = 8,
    parameter int unsigned SPAWN_PERIOD  = 120,
    parameter int unsigned RESPAWN_DELAY = 90,
    parameter int unsigned WAVE_PAUSE    = 60,
    parameter int unsigned ROCKS_BASE    = 3
) (
    input  logic                   clk_60hz,
    input  logic                   reset_game,
    object_slot_scheduler_if.slave io_bus
);

    localparam int unsigned CD_W    = $clog2(FIRE_COOLDOWN + 1);
    localparam int unsigned TMR_W   = $clog2(SPAWN_PERIOD);
    localparam int unsigned DLY_MAX = (RESPAWN_DELAY > WAVE_PAUSE) ? RESPAWN_DELAY : WAVE_PAUSE;
    localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
    localparam int unsigned CNT_W   = $clog2(N_ROCKS + 1);

    state_t               r_state, w_state_nxt;
    logic [N_SLOTS-1:0]   r_active, w_active_nxt;
    logic [N_SLOTS-1:0]   r_spawn, w_spawn_nxt;
    logic [LEVEL_W-1:0]   r_level, w_level_nxt;
    logic [CD_W-1:0]      r_cooldown, w_cooldown_nxt;
    logic [TMR_W-1:0]     r_timer, w_timer_nxt;
    logic [CNT_W-1:0]     r_spawned, w_spawned_nxt;
    logic [DLY_W-1:0]     r_delay, w_delay_nxt;

    logic                 w_live;
    logic                 w_run;
    logic [N_SLOTS-1:0]   w_freed;
    logic [N_SLOTS-1:0]   w_cand;
    logic [N_BULLETS-1:0] w_bul_grant;
    logic                 w_bul_valid;
    logic [N_ROCKS-1:0]   w_rock_grant;
    logic                 w_rock_valid;
    logic [31:0]          w_quota_sum;
    logic [CNT_W-1:0]     w_quota;
    logic                 w_wrap;
    logic                 w_fire_ok;
    logic                 w_rock_ok;
    logic                 w_rocks_live;

    assign w_live = (r_state == ST_PLAY) || (r_state == ST_RESPAWN) || (r_state == ST_WAVE_CLEAR);
    assign w_run  = (r_state == ST_PLAY) || (r_state == ST_RESPAWN);

    // A slot freed this cycle is not a spawn candidate, so freeing wins.
    assign w_freed = w_live ? (io_bus.kill | io_bus.slot_done) : '0;
    assign w_cand  = ~r_active & ~w_freed;

    lowest_free_picker #(.W(N_BULLETS)) u_bullet_pick (
        .i_free  (w_cand[BULLET_HI:BULLET_LO]),
        .o_grant (w_bul_grant),
        .o_valid (w_bul_valid)
    );

    lowest_free_picker #(.W(N_ROCKS)) u_rock_pick (
        .i_free  (w_cand[ROCK_HI:ROCK_LO]),
        .o_grant (w_rock_grant),
        .o_valid (w_rock_valid)
    );

    assign w_quota_sum  = ROCKS_BASE + {{(32 - LEVEL_W){1'b0}}, r_level};
    assign w_quota      = (w_quota_sum > N_ROCKS) ? CNT_W'(N_ROCKS) : w_quota_sum[CNT_W-1:0];
    assign w_wrap       = (r_timer == TMR_W'(SPAWN_PERIOD - 1));
    assign w_rocks_live = |r_active[ROCK_HI:ROCK_LO];

    assign w_fire_ok = w_run && r_active[SHIP_IDX] && io_bus.fire_req
                       && (r_cooldown == '0) && w_bul_valid;
    assign w_rock_ok = w_run && w_wrap && (r_spawned < w_quota) && w_rock_valid;

    always_comb begin
        w_state_nxt    = r_state;
        w_active_nxt   = r_active & ~w_freed;
        w_spawn_nxt    = '0;
        w_level_nxt    = r_level;
        w_cooldown_nxt = (r_cooldown != '0) ? r_cooldown - 1'b1 : '0;
        w_timer_nxt    = r_timer;
        w_spawned_nxt  = r_spawned;
        w_delay_nxt    = r_delay;

        case (r_state)
            ST_IDLE, ST_OVER: begin
                w_timer_nxt = '0;
                if (io_bus.start) begin
                    w_state_nxt            = ST_PLAY;
                    w_active_nxt           = '0;
                    w_active_nxt[SHIP_IDX] = 1'b1;
                    w_spawn_nxt[SHIP_IDX]  = 1'b1;
                    w_spawned_nxt          = '0;
                    w_level_nxt            = '0;
                    w_cooldown_nxt         = '0;
                end
            end

            ST_PLAY, ST_RESPAWN: begin
                w_timer_nxt = w_wrap ? '0 : r_timer + 1'b1;
                if (io_bus.game_over) begin
                    w_state_nxt  = ST_OVER;
                    w_active_nxt = '0;
                end else begin
                    if (w_fire_ok) begin
                        w_spawn_nxt[BULLET_HI:BULLET_LO]  = w_bul_grant;
                        w_active_nxt[BULLET_HI:BULLET_LO] = w_active_nxt[BULLET_HI:BULLET_LO] | w_bul_grant;
                        // Loaded one short so grants land exactly FIRE_COOLDOWN cycles apart.
                        w_cooldown_nxt = CD_W'(FIRE_COOLDOWN - 1);
                    end
                    if (w_rock_ok) begin
                        w_spawn_nxt[ROCK_HI:ROCK_LO]  = w_rock_grant;
                        w_active_nxt[ROCK_HI:ROCK_LO] = w_active_nxt[ROCK_HI:ROCK_LO] | w_rock_grant;
                        w_spawned_nxt = r_spawned + 1'b1;
                    end
                    if (r_state == ST_PLAY) begin
                        if (io_bus.kill[SHIP_IDX]) begin
                            w_state_nxt = ST_RESPAWN;
                            w_delay_nxt = DLY_W'(RESPAWN_DELAY);
                        end else if ((r_spawned == w_quota) && !w_rocks_live) begin
                            w_state_nxt = ST_WAVE_CLEAR;
                            w_delay_nxt = DLY_W'(WAVE_PAUSE);
                        end
                    end else if (r_delay <= DLY_W'(1)) begin
                        w_state_nxt            = ST_PLAY;
                        w_spawn_nxt[SHIP_IDX]  = 1'b1;
                        w_active_nxt[SHIP_IDX] = 1'b1;
                        w_delay_nxt            = '0;
                    end else begin
                        w_delay_nxt = r_delay - 1'b1;
                    end
                end
            end

            ST_WAVE_CLEAR: begin
                w_timer_nxt = '0;
                if (r_delay <= DLY_W'(1)) begin
                    w_state_nxt   = ST_PLAY;
                    w_level_nxt   = (r_level == '1) ? r_level : r_level + 1'b1;
                    w_spawned_nxt = '0;
                    w_delay_nxt   = '0;
                end else begin
                    w_delay_nxt = r_delay - 1'b1;
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_active_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_60hz) begin
        if (reset_game) begin
            r_state    <= ST_IDLE;
            r_active   <= '0;
            r_spawn    <= '0;
            r_level    <= '0;
            r_cooldown <= '0;
            r_timer    <= '0;
            r_spawned  <= '0;
            r_delay    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_active   <= w_active_nxt;
            r_spawn    <= w_spawn_nxt;
            r_level    <= w_level_nxt;
            r_cooldown <= w_cooldown_nxt;
            r_timer    <= w_timer_nxt;
            r_spawned  <= w_spawned_nxt;
            r_delay    <= w_delay_nxt;
        end
    end

    assign io_bus.spawn   = r_spawn;
    assign io_bus.active  = r_active;
    assign io_bus.level   = r_level;
    assign io_bus.state_o = r_state;

endmodule
